// File: rtl/chunked_add_seq_pkg.sv
// Shared definitions for the chunked sequential adder.
//   state_t       : FSM state encoding (S_IDLE, S_RUN, S_DONE)
//   chunk_cfg_ok  : elaboration-time check that WIDTH splits into >= 2 whole chunks
package chunked_add_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk > 0) && (width % chunk == 0) && (width / chunk >= 2);
  endfunction

endpackage

// File: rtl/chunked_add_seq_rca.sv
// rca_nbit: n-bit combinational ripple-carry adder.
//   i_a, i_b  : n-bit operands
//   i_c_in    : carry into bit 0
//   o_sum     : n-bit sum
//   o_c_out   : per-bit carry vector; o_c_out[i] is the carry out of bit i,
//               so o_c_out[n-1] is the carry out of the whole adder
module rca_nbit #(
  parameter int n = 16
) (
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  input  logic         i_c_in,
  output logic [n-1:0] o_sum,
  output logic [n-1:0] o_c_out
);

  logic w_carry;

  always_comb begin
    o_sum   = '0;
    o_c_out = '0;
    w_carry = i_c_in;
    for (int i = 0; i < n; i++) begin
      o_sum[i]   = i_a[i] ^ i_b[i] ^ w_carry;
      w_carry    = (i_a[i] & i_b[i]) | (i_a[i] & w_carry) | (i_b[i] & w_carry);
      o_c_out[i] = w_carry;
    end
  end

endmodule

// File: rtl/chunked_add_seq.sv
// chunked_add_seq: adds two WIDTH-bit operands over NCHUNK = WIDTH/CHUNK cycles
// using one shared CHUNK-bit ripple-carry adder, LSB chunk first.
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, accepted only in IDLE or DONE
//   a, b, c_in    : operands and carry-in, latched on an accepted start
//   busy          : high while in RUN
//   done          : one-cycle pulse, sum/c_out/ovf valid
//   sum           : result, stable from done until the next accepted start
//   c_out, ovf    : unsigned carry out, two's-complement overflow
//   dbg_state     : current FSM state (state_t encoding)
//
// Handshake: start is a level request that is consumed on the rising edge where
// the block is ready (IDLE or DONE); it is ignored in RUN and never queued.
// done marks the single cycle in which the result is newly valid.
module chunked_add_seq
  import chunked_add_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = $clog2(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("chunked_add_seq: WIDTH must be a multiple of CHUNK with at least 2 chunks");
    end
  endgenerate

  state_t             r_state;
  state_t             w_next_state;
  logic [IDXW-1:0]    r_idx;
  logic               r_cin;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_c_out;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic               w_chunk_cin;
  logic [CHUNK-1:0]   w_chunk_sum;
  logic [CHUNK-1:0]   w_chunk_cv;

  assign w_last      = (r_idx == LAST_IDX);
  assign w_chunk_cin = (r_idx == '0) ? r_cin : r_carry;

  rca_nbit #(.n(CHUNK)) u_rca (
    .i_a     (r_a[CHUNK-1:0]),
    .i_b     (r_b[CHUNK-1:0]),
    .i_c_in  (w_chunk_cin),
    .o_sum   (w_chunk_sum),
    .o_c_out (w_chunk_cv)
  );

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = start;
        if (start) w_next_state = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        w_accept = start;
        w_next_state = start ? S_RUN : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cin   <= 1'b0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_cin   <= c_in;
        r_carry <= 1'b0;
        r_idx   <= '0;
      end else if (r_state == S_RUN) begin
        // Operands shift down so the adder always sees the next chunk in the
        // low bits; the result fills in from the top and ends up aligned.
        r_a     <= r_a >> CHUNK;
        r_b     <= r_b >> CHUNK;
        r_sum   <= {w_chunk_sum, r_sum[WIDTH-1:CHUNK]};
        r_carry <= w_chunk_cv[CHUNK-1];
        r_idx   <= r_idx + 1'b1;
        if (w_last) begin
          // In the last chunk the low bits of r_a/r_b hold the operand MSBs.
          r_c_out <= w_chunk_cv[CHUNK-1];
          r_ovf   <= (r_a[CHUNK-1] == r_b[CHUNK-1]) &&
                     (w_chunk_sum[CHUNK-1] != r_a[CHUNK-1]);
        end
      end
    end
  end

  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_chunked_add_seq.sv
module tb_chunked_add_seq;

  logic        clk;
  logic        rst;

  logic        start64, cin64, busy64, done64, cout64, ovf64;
  logic [63:0] a64, b64, sum64;
  logic [1:0]  st64;

  logic        start34, cin34, busy34, done34, cout34, ovf34;
  logic [33:0] a34, b34, sum34;
  logic [1:0]  st34;

  int n_vec;
  int n_err;

  chunked_add_seq #(.WIDTH(64), .CHUNK(16)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .a(a64), .b(b64), .c_in(cin64),
    .busy(busy64), .done(done64), .sum(sum64), .c_out(cout64), .ovf(ovf64),
    .dbg_state(st64)
  );

  chunked_add_seq #(.WIDTH(34), .CHUNK(17)) dut34 (
    .clk(clk), .rst(rst), .start(start34), .a(a34), .b(b34), .c_in(cin34),
    .busy(busy34), .done(done34), .sum(sum34), .c_out(cout34), .ovf(ovf34),
    .dbg_state(st34)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({busy64, done64, cout64, ovf64, st64} !== 6'b0 || sum64 !== 64'd0) begin
      n_err++;
      $display("FAIL reset64: busy=%b done=%b c_out=%b ovf=%b st=%0d sum=%h, required all 0",
               busy64, done64, cout64, ovf64, st64, sum64);
    end
    n_vec++;
    if ({busy34, done34, cout34, ovf34, st34} !== 6'b0 || sum34 !== 34'd0) begin
      n_err++;
      $display("FAIL reset34: busy=%b done=%b c_out=%b ovf=%b st=%0d sum=%h, required all 0",
               busy34, done34, cout34, ovf34, st34, sum34);
    end
    rst = 1'b0;
  endtask

  // FFFF..FFFF + 1: full carry ripple, exact busy/done timeline.
  task automatic test_latency();
    logic exp_busy, exp_done;
    a64 = 64'hFFFF_FFFF_FFFF_FFFF;
    b64 = 64'd1;
    cin64 = 1'b0;
    start64 = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 0) start64 = 1'b0;
      exp_busy = (k <= 3);
      exp_done = (k == 4);
      n_vec++;
      if (busy64 !== exp_busy || done64 !== exp_done) begin
        n_err++;
        $display("FAIL latency_edge%0d: busy=%b done=%b, required busy=%b done=%b",
                 k, busy64, done64, exp_busy, exp_done);
      end
      if (k == 4 || k == 5) begin
        n_vec++;
        if (sum64 !== 64'd0 || cout64 !== 1'b1 || ovf64 !== 1'b0) begin
          n_err++;
          $display("FAIL latency_result_edge%0d: sum=%h c_out=%b ovf=%b, required sum=0 c_out=1 ovf=0",
                   k, sum64, cout64, ovf64);
        end
      end
    end
  endtask

  task automatic test_directed();
    logic [63:0] va[5], vb[5], vs[5];
    logic        vc[5], vco[5], vov[5];
    int cyc;
    va[0] = 64'h7FFF_FFFF_FFFF_FFFF; vb[0] = 64'd1;                  vc[0] = 1'b0;
    vs[0] = 64'h8000_0000_0000_0000; vco[0] = 1'b0; vov[0] = 1'b1;
    va[1] = 64'h0000_0000_0000_FFFF; vb[1] = 64'd0;                  vc[1] = 1'b1;
    vs[1] = 64'h0000_0000_0001_0000; vco[1] = 1'b0; vov[1] = 1'b0;
    va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h8000_0000_0000_0000; vc[2] = 1'b0;
    vs[2] = 64'h0000_0000_0000_0000; vco[2] = 1'b1; vov[2] = 1'b1;
    va[3] = 64'hFFFF_FFFF_FFFF_FFFF; vb[3] = 64'hFFFF_FFFF_FFFF_FFFF; vc[3] = 1'b1;
    vs[3] = 64'hFFFF_FFFF_FFFF_FFFF; vco[3] = 1'b1; vov[3] = 1'b0;
    va[4] = 64'h0123_4567_89AB_CDEF; vb[4] = 64'hFEDC_BA98_7654_3210; vc[4] = 1'b0;
    vs[4] = 64'hFFFF_FFFF_FFFF_FFFF; vco[4] = 1'b0; vov[4] = 1'b0;
    for (int v = 0; v < 5; v++) begin
      a64 = va[v];
      b64 = vb[v];
      cin64 = vc[v];
      start64 = 1'b1;
      tick();
      start64 = 1'b0;
      a64 = ~va[v];
      b64 = ~vb[v];
      cyc = 0;
      while (done64 !== 1'b1 && cyc < 20) begin
        tick();
        cyc++;
      end
      n_vec++;
      if (cyc != 4) begin
        n_err++;
        $display("FAIL directed%0d_latency: done after %0d edges, required 4", v, cyc);
      end
      n_vec++;
      if (sum64 !== vs[v] || cout64 !== vco[v] || ovf64 !== vov[v]) begin
        n_err++;
        $display("FAIL directed%0d: sum=%h c_out=%b ovf=%b, required sum=%h c_out=%b ovf=%b",
                 v, sum64, cout64, ovf64, vs[v], vco[v], vov[v]);
      end
      tick();
    end
  endtask

  // start held high: (1,2) accepted at edge 0, (3,4) at edge 5.
  task automatic test_back_to_back();
    logic exp_busy, exp_done;
    a64 = 64'd1;
    b64 = 64'd2;
    cin64 = 1'b0;
    start64 = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k == 0) begin
        a64 = 64'd3;
        b64 = 64'd4;
      end
      if (k == 9) start64 = 1'b0;
      exp_done = (k == 4) || (k == 9);
      exp_busy = (k <= 3) || (k >= 5 && k <= 8);
      n_vec++;
      if (busy64 !== exp_busy || done64 !== exp_done) begin
        n_err++;
        $display("FAIL b2b_edge%0d: busy=%b done=%b, required busy=%b done=%b",
                 k, busy64, done64, exp_busy, exp_done);
      end
      if (k == 4 || k == 9) begin
        n_vec++;
        if (sum64 !== ((k == 4) ? 64'd3 : 64'd7)) begin
          n_err++;
          $display("FAIL b2b_sum_edge%0d: sum=%h, required %0d", k, sum64, (k == 4) ? 3 : 7);
        end
      end
    end
    n_vec++;
    if (st64 !== 2'd0) begin
      n_err++;
      $display("FAIL b2b_idle: state=%0d, required 0", st64);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    a64 = 64'h1111_2222_3333_4444;
    b64 = 64'h1111_1111_1111_1111;
    cin64 = 1'b0;
    start64 = 1'b1;
    tick();
    start64 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({busy64, done64, cout64, ovf64, st64} !== 6'b0 || sum64 !== 64'd0) begin
      n_err++;
      $display("FAIL midrun_reset: busy=%b done=%b c_out=%b ovf=%b st=%0d sum=%h, required all 0",
               busy64, done64, cout64, ovf64, st64, sum64);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_vec++;
      if (done64 !== 1'b0 || busy64 !== 1'b0) begin
        n_err++;
        $display("FAIL midrun_quiet%0d: done=%b busy=%b, required 0 0", k, done64, busy64);
      end
    end
    a64 = 64'd5;
    b64 = 64'd6;
    start64 = 1'b1;
    tick();
    start64 = 1'b0;
    cyc = 0;
    while (done64 !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    n_vec++;
    if (cyc != 4 || sum64 !== 64'd11 || cout64 !== 1'b0 || ovf64 !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_restart: edges=%0d sum=%h c_out=%b ovf=%b, required 4 11 0 0",
               cyc, sum64, cout64, ovf64);
    end
    tick();
  endtask

  task automatic test_random34();
    logic [63:0] t;
    logic [34:0] ref_full;
    logic        exp_ovf;
    int cyc;
    for (int i = 0; i < 1000; i++) begin
      t = {$urandom, $urandom};
      a34 = t[33:0];
      t = {$urandom, $urandom};
      b34 = t[33:0];
      cin34 = 1'($urandom_range(1, 0));
      if (i == 0) begin a34 = '1; b34 = 34'd1; cin34 = 1'b0; end
      if (i == 1) begin a34 = 34'h1_FFFF; b34 = 34'd0; cin34 = 1'b1; end
      if (i == 2) begin a34 = 34'h2_0000_0000; b34 = 34'h2_0000_0000; cin34 = 1'b0; end
      if (i == 3) begin a34 = 34'h1_FFFF_FFFF; b34 = 34'd0; cin34 = 1'b1; end
      ref_full = {1'b0, a34} + {1'b0, b34} + {34'd0, cin34};
      exp_ovf = (a34[33] == b34[33]) && (ref_full[33] != a34[33]);
      start34 = 1'b1;
      tick();
      start34 = 1'b0;
      cyc = 0;
      while (done34 !== 1'b1 && cyc < 20) begin
        tick();
        cyc++;
      end
      n_vec++;
      if (cyc != 2 || sum34 !== ref_full[33:0] || cout34 !== ref_full[34] || ovf34 !== exp_ovf) begin
        n_err++;
        $display("FAIL rand34_%0d: edges=%0d sum=%h c_out=%b ovf=%b, required 2 %h %b %b",
                 i, cyc, sum34, cout34, ovf34, ref_full[33:0], ref_full[34], exp_ovf);
      end
      tick();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    start64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0;
    start34 = 1'b0; a34 = '0; b34 = '0; cin34 = 1'b0;
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_random34();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
